// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with a two-entry skid buffer. It splits the
// MAIN instruction into MIPS fields and selects the immediate extension mode.
module if_id_stage #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc4,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [15:0]       out_imm16,
  output logic              ext_signed,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a word transfers on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the payload is stable while valid waits.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      main_instr_q, main_instr_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_ready  = (state_q != FULL) & ~flush & rst_n;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign dbg_state = state_q;

  // Flush wins over everything and leaves the data registers untouched.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (load_main_in) begin
      main_instr_d = in_instr;
      main_pc_d    = in_pc;
    end else if (load_main_skid) begin
      main_instr_d = skid_instr_q;
      main_pc_d    = skid_pc_q;
    end
    if (load_skid) begin
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end
  end

  // Saturating count of back-pressured cycles; flush does not clear it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign out_pc4   = main_pc_q + PC_W'(4);
  assign out_rs    = main_instr_q[25:21];
  assign out_rt    = main_instr_q[20:16];
  assign out_rd    = main_instr_q[15:11];
  assign out_shamt = main_instr_q[10:6];
  assign out_funct = main_instr_q[5:0];
  assign out_imm16 = main_instr_q[15:0];
  assign stall_cnt = stall_cnt_q;

  // Branches, arithmetic immediates, slti/sltiu and loads/stores sign-extend;
  // logical immediates and lui zero-extend.
  always_comb begin
    ext_signed = 1'b0;
    case (main_instr_q[31:26])
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: ext_signed = 1'b1;
      default: ext_signed = 1'b0;
    endcase
  end

endmodule
